munoc_aw_burst_splitter: RTL
============================

MUNOC_AW_BURST_SPLITTER -- requirements
Module: munoc_aw_burst_splitter

Interface
REQ-001 SHALL have parameter BW_ADDR, default 32, address width.
REQ-002 SHALL have parameter BW_ID, default 8, width of {master node id, tid}.
REQ-003 SHALL have parameter MAX_SUB_LEN, default 16, max beats per sub-burst; power of 2, 16..256.
REQ-004 SHALL have parameter BW_COUNT, default 8, width of the sub-burst count field; must hold 255/MAX_SUB_LEN.
REQ-005 SHALL have ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_awvalid  in  1  upstream AW valid
- s_awready  out  1  upstream AW ready
- s_awid  in  BW_ID  request id
- s_awaddr  in  BW_ADDR  start address
- s_awlen  in  8  beats-1
- s_awsize  in  3  log2 bytes per beat
- s_awburst  in  2  FIXED=0, INCR=1, WRAP=2
- m_awvalid, m_awready, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst  out/in/out...  same widths  downstream sub-burst AW
- trk_valid  out  1  tracking-entry push to the B-response merger
- trk_ready  in  1  tracking FIFO not full
- trk_data  out  BW_ID+BW_COUNT  {id, sub-burst count-1}

Function
REQ-006 SHALL have two states, IDLE and ISSUE.
REQ-007 In IDLE, trk_valid = s_awvalid and s_awready = trk_ready; an AW is accepted iff s_awvalid & trk_ready, with the tracking push occurring in the same cycle.
REQ-008 SHALL set trk_data count = s_awlen >> log2(MAX_SUB_LEN) for FIXED/INCR, and 0 for WRAP.
REQ-009 On acceptance, SHALL register id, addr, size, burst, and rem = s_awlen, then enter ISSUE; the first m_awvalid is asserted the cycle after acceptance.
REQ-010 In ISSUE, SHALL drive m_awvalid=1 and m_awlen = min(rem, MAX_SUB_LEN-1), with the registered id/addr/size/burst; s_awready=0 and trk_valid=0.
REQ-011 All m_aw* outputs SHALL stay stable while m_awvalid & !m_awready.
REQ-012 On m_awvalid & m_awready with rem <= MAX_SUB_LEN-1, SHALL return to IDLE, giving one idle bubble before the next acceptance.
REQ-013 On m_awvalid & m_awready with rem >= MAX_SUB_LEN, SHALL set rem -= MAX_SUB_LEN and update addr: INCR adds MAX_SUB_LEN<<size modulo 2^BW_ADDR; FIXED leaves addr unchanged.
REQ-014 WRAP bursts SHALL pass through as a single sub-burst, unchanged.
REQ-015 The total sub-bursts issued per accepted AW SHALL equal the trk_data count+1.
REQ-016 Sub-burst order SHALL be ascending; no interleaving across accepted AWs.
REQ-017 trk_ready low in IDLE SHALL hold s_awready low; no state change occurs.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, rem=0, and registered fields to 0; m_awvalid=0, trk_valid=0, s_awready=0 while rst is high.
REQ-019 Reset mid-ISSUE SHALL abandon the remaining sub-bursts with no further outputs; tracking consistency is restored by the network-wide reset.

Structure
REQ-020 SHALL take burst encodings, the trk_data field layout, and the BW_COUNT derivation from the shared package munoc_aw_split_pkg, also used by the B-response merger.
REQ-021 SHALL be a single flat module with no sub-module; the FSM, rem counter and address adder are inline.

Verification (MAX_SUB_LEN=16)
REQ-022 INCR, addr 0x1000, len 7, size 2 -> one sub-burst (0x1000, len 7); trk count 0.
REQ-023 INCR, addr 0x2000, len 63, size 3 -> sub-bursts at 0x2000/0x2080/0x2100/0x2180, each len 15; trk count 3.
REQ-024 FIXED, addr 0x30, len 20 -> (0x30, len 15) then (0x30, len 4); trk count 1.
REQ-025 WRAP, addr 0x40, len 15 -> single pass-through; trk count 0; trk_ready=0 for 3 cycles -> s_awready=0, no m_awvalid.
REQ-026 Hold m_awready=0 for 5 cycles mid-split -> m_aw* stable; rst pulse during the 2nd of 4 sub-bursts -> m_awvalid=0 immediately and IDLE after release.

Source files
------------

// File: rtl/munoc_aw_split_pkg.sv
// Shared definitions for the AW burst splitter and the B-response merger:
// burst encodings, tracking-entry layout and sub-burst count derivation.
package munoc_aw_split_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } split_state_e;

    // AXI4 maximum burst length expressed as len (beats-1).
    localparam int unsigned AXI_MAX_LEN = 255;

    // Minimum count-field width able to hold AXI_MAX_LEN / max_sub_len.
    function automatic int unsigned min_bw_count(input int unsigned max_sub_len);
        return (AXI_MAX_LEN / max_sub_len) < 2 ? 1 : $clog2((AXI_MAX_LEN / max_sub_len) + 1);
    endfunction

    // Number of sub-bursts minus one; WRAP bursts are never split.
    // The tracking entry is laid out as {id, sub_count}.
    function automatic logic [7:0] sub_count(input logic [7:0] len,
                                             input logic [1:0] burst,
                                             input int unsigned shift);
        return (burst == BURST_WRAP) ? 8'd0 : (len >> shift);
    endfunction

endpackage

// File: rtl/munoc_aw_burst_splitter.sv
// Splits upstream AW bursts into sub-bursts of at most MAX_SUB_LEN beats and
// pushes one tracking entry per accepted AW so B responses can be merged.
module munoc_aw_burst_splitter
    import munoc_aw_split_pkg::*;
#(
    parameter int BW_ADDR     = 32,
    parameter int BW_ID       = 8,
    parameter int MAX_SUB_LEN = 16,
    parameter int BW_COUNT    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [BW_ID-1:0]          s_awid,
    input  logic [BW_ADDR-1:0]        s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic [2:0]                s_awsize,
    input  logic [1:0]                s_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [BW_ID-1:0]          m_awid,
    output logic [BW_ADDR-1:0]        m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      trk_valid,
    input  logic                      trk_ready,
    output logic [BW_ID+BW_COUNT-1:0] trk_data
);

    localparam int unsigned SHIFT   = $clog2(MAX_SUB_LEN);
    localparam logic [7:0]  SUB_MAX = 8'(MAX_SUB_LEN - 1);
    localparam logic [7:0]  SUB_LEN = 8'(MAX_SUB_LEN);

    split_state_e        state_q, state_d;
    logic [BW_ID-1:0]    id_q, id_d;
    logic [BW_ADDR-1:0]  addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [7:0]          rem_q, rem_d;
    logic                last_sub;

    // Final sub-burst: the remainder fits, or the burst is a WRAP pass-through.
    assign last_sub = (rem_q <= SUB_MAX) || (burst_q == BURST_WRAP);

    // Registered fields drive the downstream channel directly so they hold
    // steady under backpressure.
    assign m_awid    = id_q;
    assign m_awaddr  = addr_q;
    assign m_awsize  = size_q;
    assign m_awburst = burst_q;
    assign m_awlen   = last_sub ? rem_q : SUB_MAX;
    assign trk_data  = {s_awid, BW_COUNT'(sub_count(s_awlen, s_awburst, SHIFT))};

    // Next-state and handshake logic.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        size_d    = size_q;
        burst_d   = burst_q;
        rem_d     = rem_q;
        s_awready = 1'b0;
        trk_valid = 1'b0;
        m_awvalid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Reset holds the upstream handshake closed even though the
                // state already reads IDLE.
                s_awready = trk_ready & ~rst;
                trk_valid = s_awvalid & ~rst;
                if (s_awvalid && trk_ready) begin
                    id_d    = s_awid;
                    addr_d  = s_awaddr;
                    size_d  = s_awsize;
                    burst_d = s_awburst;
                    rem_d   = s_awlen;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    if (last_sub) begin
                        state_d = ST_IDLE;
                    end else begin
                        rem_d = rem_q - SUB_LEN;
                        if (burst_q == BURST_INCR)
                            addr_d = addr_q + (BW_ADDR'(MAX_SUB_LEN) << size_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            rem_q   <= rem_d;
        end
    end

endmodule
